// File: rtl/adc_dupla_rampa.sv
// Dual-slope ADC controller: auto-zero / integrate / de-integrate sequencing plus an N-digit BCD counter.
// Optional seven-segment result decode on port sgm when ADC_SGM_EN is defined.
module adc_dupla_rampa #(
    parameter int unsigned DIGITS      = 3,
    parameter int unsigned ZERO_CYCLES = 16
) (
    input  logic                  ck,
    input  logic                  rst,
    input  logic                  inicio,
    input  logic                  continuo,
    input  logic                  Vint_z,
    input  logic                  comp_pos,
    output logic                  ch_zr,
    output logic                  ch_vm,
    output logic                  ch_ref_p,
    output logic                  ch_ref_n,
    output logic [4*DIGITS-1:0]   resultado,
    output logic                  sinal,
    output logic                  sobrefaixa,
    output logic                  valido,
    output logic                  ocupado
`ifdef ADC_SGM_EN
    ,
    output logic [7*DIGITS-1:0]   sgm
`endif
);

    localparam int unsigned ZW = $clog2(ZERO_CYCLES + 1);

    typedef enum logic [2:0] {OCIOSO, ZERA, INTEGRA, DESINTEGRA, CARREGA} state_t;

    function automatic logic [4*DIGITS-1:0] all_nines();
        logic [4*DIGITS-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'd9;
        return r;
    endfunction

    localparam logic [4*DIGITS-1:0] NINES = all_nines();

    function automatic logic [4*DIGITS-1:0] bcd_inc(input logic [4*DIGITS-1:0] v);
        logic [4*DIGITS-1:0] r;
        logic                carry;
        r     = v;
        carry = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

`ifdef ADC_SGM_EN
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    function automatic logic [7*DIGITS-1:0] sgm_of(input logic [4*DIGITS-1:0] v, input logic ovr);
        logic [7*DIGITS-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < DIGITS; i++) r[7*i +: 7] = ovr ? 7'h40 : seg7(v[4*i +: 4]);
        return r;
    endfunction
`endif

    state_t              state;
    logic [4*DIGITS-1:0] count;
    logic [ZW-1:0]       zcnt;
    logic                pol;

    always_ff @(posedge ck) begin
        if (rst) begin
            state      <= OCIOSO;
            count      <= '0;
            zcnt       <= '0;
            pol        <= 1'b0;
            ch_zr      <= 1'b1;
            ch_vm      <= 1'b0;
            ch_ref_p   <= 1'b0;
            ch_ref_n   <= 1'b0;
            resultado  <= '0;
            sinal      <= 1'b0;
            sobrefaixa <= 1'b0;
            valido     <= 1'b0;
            ocupado    <= 1'b0;
`ifdef ADC_SGM_EN
            sgm        <= '0;
`endif
        end else begin
            valido <= 1'b0;
            case (state)
                OCIOSO: begin
                    if (inicio) begin
                        state   <= ZERA;
                        zcnt    <= '0;
                        ocupado <= 1'b1;
                    end
                end
                ZERA: begin
                    if (zcnt == ZW'(ZERO_CYCLES - 1)) begin
                        state <= INTEGRA;
                        count <= '0;
                        ch_zr <= 1'b0;
                        ch_vm <= 1'b1;
                    end else begin
                        zcnt <= zcnt + ZW'(1);
                    end
                end
                INTEGRA: begin
                    count <= bcd_inc(count);
                    if (count == NINES) begin
                        state    <= DESINTEGRA;
                        pol      <= comp_pos;
                        ch_vm    <= 1'b0;
                        ch_ref_n <= comp_pos;
                        ch_ref_p <= ~comp_pos;
                    end
                end
                DESINTEGRA: begin
                    count <= bcd_inc(count);
                    // On the overrange exit count is already all-9s, so count is the result in both cases
                    if (Vint_z || count == NINES) begin
                        state      <= CARREGA;
                        resultado  <= count;
                        sobrefaixa <= ~Vint_z;
                        sinal      <= ~pol;
                        valido     <= 1'b1;
                        ch_ref_p   <= 1'b0;
                        ch_ref_n   <= 1'b0;
                        ch_zr      <= 1'b1;
`ifdef ADC_SGM_EN
                        sgm        <= sgm_of(count, ~Vint_z);
`endif
                    end
                end
                CARREGA: begin
                    zcnt <= '0;
                    if (continuo) begin
                        state <= ZERA;
                    end else begin
                        state   <= OCIOSO;
                        ocupado <= 1'b0;
                    end
                end
                default: begin
                    state    <= OCIOSO;
                    ch_zr    <= 1'b1;
                    ch_vm    <= 1'b0;
                    ch_ref_p <= 1'b0;
                    ch_ref_n <= 1'b0;
                    ocupado  <= 1'b0;
                end
            endcase
        end
    end

endmodule
